ps2_keyboard_rx: RTL and testbench
==================================

# ps2_keyboard_rx

Receive-side user-input peripheral for the Nexys board: a PS/2 keyboard receiver that turns the asynchronous PS/2 clock/data line pair into decoded scan-code events with a valid/ready handshake. It sits beside the seven-segment output path and feeds key events to the core's periphery-load path or to board-level glue. It performs line synchronization, clock deglitching, 11-bit frame decoding, odd-parity checking, timeout recovery, and folding of the `E0`/`F0` prefixes into event flags.

## Interface
- `SYNC_STAGES`, 3: flip-flop stages on each PS/2 input; minimum 2.
- `FILTER_LEN`, 8: consecutive identical samples needed before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, 100000: idle cycles allowed between falling edges inside a frame before the frame is aborted (1 ms at 100 MHz).
- `clk_i` input 1: system clock (100 MHz).
- `arstn_i` input 1: reset. Synchronous, active-low; sampled on the rising edge of `clk_i`.
- `ps2_clk_i` input 1: raw PS/2 clock from the keyboard, asynchronous.
- `ps2_data_i` input 1: raw PS/2 data, asynchronous.
- `key_o` output 8: scan code, excluding prefixes.
- `ext_o` output 1: `E0` prefix preceded this code.
- `release_o` output 1: `F0` prefix preceded this code (key break).
- `valid_o` output 1: an event is held on `key_o`/`ext_o`/`release_o`.
- `ready_i` input 1: consumer accepts the event.
- `err_o` output 1: one-cycle pulse on a parity, start, stop or timeout error.
- `overflow_o` output 1: one-cycle pulse when a completed event is dropped.

## Operation
- **Synchronizers:** both inputs pass through `SYNC_STAGES` flops. On reset all stages load 1, the idle line level.
- **Clock filter:**
  - Filtered clock resets to 1.
  - It takes the synchronized level only after that level has differed from the filtered value for `FILTER_LEN` consecutive cycles. The counter clears whenever the two levels agree.
  - A falling edge is a 1→0 change of the filtered clock. Data is sampled from the synchronized data line in that same cycle.
- **Frame:** start bit 0, then 8 data bits LSB first, then the odd-parity bit, then stop bit 1.
- **FSM states:**
  - `IDLE`: edge with data 0 → `DATA`, bit counter cleared. Edge with data 1 → `err_o` pulse, stay in `IDLE`.
  - `DATA`: each edge shifts in a bit. After the 8th bit → `PARITY`.
  - `PARITY`: the edge samples the parity bit. The parity result is latched; the sum of ones over data+parity must be odd. → `STOP`.
  - `STOP`: edge with data 1 and parity OK → byte complete, → `IDLE`. Edge with data 0, or parity bad → `err_o`, no byte, → `IDLE`.
- **Timeout:** a counter clears on every edge and counts in all states except `IDLE`. On reaching `TIMEOUT_CYCLES` → `err_o`, → `IDLE`, partial byte discarded.
- **Prefix folding:**
  - Completed byte `E0` sets `ext_pend`; completed byte `F0` sets `rel_pend`. Neither is emitted.
  - Any other byte is emitted with `ext_o = ext_pend` and `release_o = rel_pend`; both pend flags then clear.
  - Any error clears both pend flags.
- **Output buffer (single entry):**
  - An event is loaded when the buffer is empty, or when the buffer is being drained in the same cycle (`valid_o && ready_i`).
  - A non-prefix byte that completes while `valid_o && !ready_i` is dropped, pulses `overflow_o`, and clears the pend flags. The held event is unchanged.
  - While `valid_o` is 1, `key_o`/`ext_o`/`release_o` are stable.

## Timing
- **Reset values:** `key_o` = 0x00, `ext_o` = 0, `release_o` = 0, `valid_o` = 0, `err_o` = 0, `overflow_o` = 0. FSM in `IDLE`; counters and pend flags 0.
- **Reset mid-frame:** the frame is abandoned. The next start bit is decoded normally.
- **Input latency:** raw pin to filtered edge = `SYNC_STAGES` + `FILTER_LEN` cycles.
- **Output latency:**
  - `valid_o` rises on the cycle after the stop-bit edge.
  - `err_o` pulses on the cycle after the offending edge, or on the cycle after the timeout count is reached.
  - `overflow_o` pulses in the same cycle `valid_o` would have risen.
- **Handshake:**
  - Transfer occurs on a rising `clk_i` edge with `valid_o && ready_i`.
  - `valid_o` drops the next cycle unless a new event loads in that same cycle.
  - `ready_i` may be held high permanently.

## Test plan
- **Make code:** frame 0x1C (parity 0, stop 1), `ready_i` = 1 → one `valid_o` pulse, `key_o` = 0x1C, `ext_o` = 0, `release_o` = 0, `err_o` never high.
- **Break and extended:** frames F0,1C → single event `key_o` = 0x1C, `release_o` = 1. Then frames E0,F0,75 → `key_o` = 0x75, `ext_o` = 1, `release_o` = 1. Exactly two `valid_o` handshakes total.
- **Errors:**
  - 0x1C with parity 1 → `err_o` pulse, no `valid_o`.
  - Stop bit 0 → `err_o`.
  - Start bit 1 → `err_o`.
  - Each error followed by a clean 0x29 frame → `key_o` = 0x29.
- **Timeout:** start bit plus 4 data bits, then the line idles for `TIMEOUT_CYCLES` → `err_o` exactly `TIMEOUT_CYCLES` cycles after the last edge. A following 0x5A frame decodes correctly.
- **Backpressure:** `ready_i` = 0, frames 0x1C then 0x32 → `key_o` holds 0x1C, `overflow_o` pulses once. With `ready_i` = 1 in the exact completion cycle of 0x32 → 0x32 loads, no overflow.
- **Glitches and reset:**
  - Glitch pulses of `FILTER_LEN`−1 cycles on `ps2_clk_i` → ignored.
  - `arstn_i` = 0 for one cycle mid-frame → all outputs at reset values; the next 0x1C frame decodes correctly.

Source files
------------

// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if: key-event bundle between the PS/2 receiver and its consumer.
//   key_o[7:0]  scan code with the E0/F0 prefixes removed
//   ext_o       an E0 prefix preceded the code
//   release_o   an F0 prefix preceded the code (key break)
//   valid_o     an event is held on key_o/ext_o/release_o
//   ready_i     consumer accepts the held event
//   err_o       one-cycle pulse on a frame error or timeout
//   overflow_o  one-cycle pulse when a completed event is dropped
// master = receiver side, slave = consumer side.
interface ps2_keyboard_rx_if;
  logic [7:0] key_o;
  logic       ext_o;
  logic       release_o;
  logic       valid_o;
  logic       ready_i;
  logic       err_o;
  logic       overflow_o;

  modport master (
    output key_o, ext_o, release_o, valid_o, err_o, overflow_o,
    input  ready_i
  );

  modport slave (
    input  key_o, ext_o, release_o, valid_o, err_o, overflow_o,
    output ready_i
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver. Synchronizes and deglitches the
// PS/2 clock, decodes 11-bit frames (start, 8 data LSB first, odd parity,
// stop), recovers from stalled frames, folds E0/F0 prefixes into flags and
// presents each key event through a single-entry valid/ready buffer.
//   clk_i       system clock
//   arstn_i     synchronous active-low reset
//   ps2_clk_i   raw PS/2 clock (asynchronous)
//   ps2_data_i  raw PS/2 data (asynchronous)
//   evt         key-event bundle (master side)
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | waiting for a start bit
// ST_DATA   | shifting in the 8 data bits
// ST_PARITY | next edge samples the parity bit
// ST_STOP   | next edge samples the stop bit
module ps2_keyboard_rx #(
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              ps2_clk_i,
  input  logic              ps2_data_i,
  ps2_keyboard_rx_if.master evt
);

  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_s, data_s;

  logic             filt_q, filt_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic             fall;

  logic [1:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_ok_q, par_ok_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             byte_done, frame_err;

  logic       ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
  logic [7:0] key_q, key_d;
  logic       ext_q, ext_d, rel_q, rel_d;
  logic       valid_q, valid_d, err_q, err_d, ovf_q, ovf_d;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // Filtered clock follows the synchronized level only after FILTER_LEN
  // consecutive disagreeing samples; the edge is the cycle it drops to 0.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (clk_s != filt_q) begin
      if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) filt_d = clk_s;
      else flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    tmo_d     = (state_q == ST_IDLE) ? '0 : tmo_q + 1'b1;
    byte_done = 1'b0;
    frame_err = 1'b0;
    if (fall) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_err = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d = {data_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
        ST_PARITY: begin
          par_ok_d = ^{data_s, shift_q};
          state_d  = ST_STOP;
        end
        default: begin
          if (data_s && par_ok_q) byte_done = 1'b1;
          else frame_err = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      // Count would reach TIMEOUT_CYCLES on this edge: abandon the frame.
      frame_err = 1'b1;
      state_d   = ST_IDLE;
      tmo_d     = '0;
    end
  end

  always_comb begin
    ext_pend_d = ext_pend_q;
    rel_pend_d = rel_pend_q;
    key_d      = key_q;
    ext_d      = ext_q;
    rel_d      = rel_q;
    valid_d    = valid_q;
    err_d      = frame_err;
    ovf_d      = 1'b0;
    if (valid_q && evt.ready_i) valid_d = 1'b0;
    if (frame_err) begin
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
    end else if (byte_done) begin
      if (shift_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        rel_pend_d = 1'b1;
      end else begin
        ext_pend_d = 1'b0;
        rel_pend_d = 1'b0;
        // A same-cycle drain frees the entry for the new event.
        if (!valid_q || evt.ready_i) begin
          key_d   = shift_q;
          ext_d   = ext_pend_q;
          rel_d   = rel_pend_q;
          valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      flt_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_ok_q    <= 1'b0;
      tmo_q       <= '0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      key_q       <= 8'h00;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      filt_q      <= filt_d;
      flt_cnt_q   <= flt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      tmo_q       <= tmo_d;
      ext_pend_q  <= ext_pend_d;
      rel_pend_q  <= rel_pend_d;
      key_q       <= key_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt.key_o      = key_q;
  assign evt.ext_o      = ext_q;
  assign evt.release_o  = rel_q;
  assign evt.valid_o    = valid_q;
  assign evt.err_o      = err_q;
  assign evt.overflow_o = ovf_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: directed bench for ps2_keyboard_rx. Drives PS/2 frames
// bit by bit and compares decoded events, error and overflow pulses against
// hand-computed values.
module tb_ps2_keyboard_rx;
  localparam int SYNC = 3;
  localparam int FILT = 8;
  localparam int TMO  = 1000;
  localparam int HALF = 20;
  localparam int GAP  = 40;

  logic clk_i = 1'b0;
  logic arstn_i = 1'b0;
  logic ps2_clk_i = 1'b1;
  logic ps2_data_i = 1'b1;

  ps2_keyboard_rx_if evt ();

  ps2_keyboard_rx #(
    .SYNC_STAGES   (SYNC),
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .evt       (evt)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  logic [9:0] evq[$];

  always @(negedge clk_i) begin
    if (evt.valid_o && evt.ready_i) evq.push_back({evt.ext_o, evt.release_o, evt.key_o});
    if (evt.err_o) err_cnt++;
    if (evt.overflow_o) ovf_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_event(input string tag, input int idx, input logic [7:0] key,
                           input logic ext, input logic rel);
    logic [9:0] ev;
    ev = (idx < evq.size()) ? evq[idx] : 10'h3FF;
    chk(tag, {22'd0, ev}, {22'd0, ext, rel, key});
  endtask

  task automatic clear_log();
    evq.delete();
    err_cnt = 0;
    ovf_cnt = 0;
  endtask

  task automatic send_bit(input logic b);
    ps2_data_i = b;
    repeat (HALF) @(posedge clk_i);
    #1 ps2_clk_i = 1'b0;
    repeat (HALF) @(posedge clk_i);
    #1 ps2_clk_i = 1'b1;
  endtask

  // rdy_stop raises ready_i in the exact cycle the stop-bit edge is decoded.
  task automatic send_frame(input logic [7:0] b, input logic par_bad,
                            input logic stop_b, input bit rdy_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ par_bad);
    ps2_data_i = stop_b;
    repeat (HALF) @(posedge clk_i);
    #1 ps2_clk_i = 1'b0;
    if (rdy_stop) begin
      repeat (SYNC + FILT - 1) @(posedge clk_i);
      #1 evt.ready_i = 1'b1;
      repeat (HALF - SYNC - FILT + 1) @(posedge clk_i);
    end else begin
      repeat (HALF) @(posedge clk_i);
    end
    #1 ps2_clk_i = 1'b1;
    ps2_data_i = 1'b1;
    repeat (GAP) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit seen;
    evt.ready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_key", {24'd0, evt.key_o}, 32'h00);
    chk("rst_flags", {28'd0, evt.ext_o, evt.release_o, evt.err_o, evt.overflow_o}, 32'h0);
    chk("rst_valid", {31'd0, evt.valid_o}, 32'h0);
    @(posedge clk_i);
    #1 arstn_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;

    // Make code
    clear_log();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("make_cnt", evq.size(), 1);
    chk_event("make_ev", 0, 8'h1C, 1'b0, 1'b0);
    chk("make_err", err_cnt, 0);

    // Break and extended break
    clear_log();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    chk("brk_cnt", evq.size(), 2);
    chk_event("brk_ev0", 0, 8'h1C, 1'b0, 1'b1);
    chk_event("brk_ev1", 1, 8'h75, 1'b1, 1'b1);

    // Parity error then clean frame
    clear_log();
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    chk("par_err", err_cnt, 1);
    chk("par_noev", evq.size(), 0);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    chk_event("par_rec", 0, 8'h29, 1'b0, 1'b0);

    // Stop bit 0 then clean frame
    clear_log();
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("stop_err", err_cnt, 1);
    chk("stop_noev", evq.size(), 0);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    chk_event("stop_rec", 0, 8'h29, 1'b0, 1'b0);

    // Start bit 1 then clean frame
    clear_log();
    send_bit(1'b1);
    repeat (GAP) @(posedge clk_i);
    #1;
    chk("start_err", err_cnt, 1);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    chk_event("start_rec", 0, 8'h29, 1'b0, 1'b0);
    chk("start_cnt", evq.size(), 1);

    // Timeout after start + 4 data bits of 0x5A
    clear_log();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data_i = 1'b1;
    repeat (HALF) @(posedge clk_i);
    #1 ps2_clk_i = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < SYNC + FILT + TMO + 100) begin
      @(posedge clk_i);
      n++;
      if (n == HALF) #1 ps2_clk_i = 1'b1;
      @(negedge clk_i);
      if (evt.err_o) seen = 1'b1;
    end
    chk("tmo_lat", n, SYNC + FILT + TMO);
    @(posedge clk_i);
    #1;
    chk("tmo_err", err_cnt, 1);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    chk_event("tmo_rec", 0, 8'h5A, 1'b0, 1'b0);
    chk("tmo_cnt", evq.size(), 1);

    // Backpressure: second event dropped
    clear_log();
    evt.ready_i = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("bp_key", {24'd0, evt.key_o}, 32'h1C);
    chk("bp_valid", {31'd0, evt.valid_o}, 32'h1);
    chk("bp_ovf", ovf_cnt, 1);
    @(posedge clk_i);
    #1 evt.ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("bp_cnt", evq.size(), 1);
    chk_event("bp_drain", 0, 8'h1C, 1'b0, 1'b0);

    // Backpressure released in the exact completion cycle
    clear_log();
    evt.ready_i = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b1);
    chk("bpx_ovf", ovf_cnt, 0);
    chk("bpx_cnt", evq.size(), 2);
    chk_event("bpx_ev0", 0, 8'h1C, 1'b0, 1'b0);
    chk_event("bpx_ev1", 1, 8'h32, 1'b0, 1'b0);

    // Glitches shorter than the filter, data high so a false edge would error
    clear_log();
    ps2_data_i = 1'b1;
    for (int g = 0; g < 5; g++) begin
      @(posedge clk_i);
      #1 ps2_clk_i = 1'b0;
      repeat (FILT - 1) @(posedge clk_i);
      #1 ps2_clk_i = 1'b1;
      repeat (20) @(posedge clk_i);
    end
    #1;
    chk("glitch_err", err_cnt, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk_event("glitch_rec", 0, 8'h1C, 1'b0, 1'b0);

    // Reset mid-frame with an event held and an E0 pending
    clear_log();
    evt.ready_i = 1'b0;
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(posedge clk_i);
    #1 arstn_i = 1'b0;
    ps2_data_i = 1'b1;
    @(posedge clk_i);
    #1 arstn_i = 1'b1;
    @(negedge clk_i);
    chk("mrst_valid", {31'd0, evt.valid_o}, 32'h0);
    chk("mrst_key", {24'd0, evt.key_o}, 32'h00);
    chk("mrst_flags", {28'd0, evt.ext_o, evt.release_o, evt.err_o, evt.overflow_o}, 32'h0);
    @(posedge clk_i);
    #1 evt.ready_i = 1'b1;
    clear_log();
    repeat (GAP) @(posedge clk_i);
    #1;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("mrst_cnt", evq.size(), 1);
    chk_event("mrst_rec", 0, 8'h1C, 1'b0, 1'b0);
    chk("mrst_err", err_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
